// File: rtl/dc_offset_remover.sv
// rtl/dc_offset_remover.sv - per-channel DC offset subtractor with averaging calibration
//
// Aligns unsigned ADC codes into a wide fixed-point word and subtracts a
// per-channel offset. Offsets are either written at runtime or measured by an
// on-demand calibration that averages 2^CAL_LOG2 samples per channel.
// Optional build macro: DC_OFS_SAT_EN (clamp result to DATA_W+FRAC_SHIFT signed bits).
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   in_valid, in_ch, in_data          input sample stream (in_ch >= NCH is dropped)
//   offset_wr, offset_wr_ch/_data     runtime offset register write
//   cal_start                         pulse that starts a calibration run
//   cal_busy, cal_done                calibration in progress / offsets applied pulse
//   out_valid, out_ch, out_data       result stream, 2-cycle latency
//   out_sat                           result was clamped (0 without DC_OFS_SAT_EN)

module dc_offset_remover #(
    parameter int                DATA_W         = 24,
    parameter int                FRAC_SHIFT     = 8,
    parameter int                OUT_W          = 64,
    parameter int                NCH            = 2,
    parameter int                CAL_LOG2       = 10,
    parameter logic [OUT_W-1:0]  DEFAULT_OFFSET = 64'h00000000AACCCCCD,
    localparam int               CH_W           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              offset_wr,
    input  logic [CH_W-1:0]   offset_wr_ch,
    input  logic [OUT_W-1:0]  offset_wr_data,
    input  logic              cal_start,
    output logic              cal_busy,
    output logic              cal_done,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int ALIGN_W = DATA_W + FRAC_SHIFT;
    localparam int ACC_W   = ALIGN_W + CAL_LOG2;
    localparam int CNT_W   = CAL_LOG2 + 1;
    localparam logic [CNT_W-1:0] CAL_N = CNT_W'(1) << CAL_LOG2;

    typedef enum logic [1:0] {IDLE, ACCUM, APPLY} state_t;

    state_t              state_q, state_d;

    logic                s1_valid_q, s1_valid_d;
    logic [CH_W-1:0]     s1_ch_q, s1_ch_d;
    logic [ALIGN_W-1:0]  s1_aligned_q, s1_aligned_d;

    // Runtime writes travel through a stage-1 register alongside samples, so a
    // sample presented in the same cycle as a write is still processed with the
    // old offset and the next sample sees the new one.
    logic                wr_pend_q, wr_pend_d;
    logic [CH_W-1:0]     wr_ch_q, wr_ch_d;
    logic [OUT_W-1:0]    wr_data_q, wr_data_d;

    logic [OUT_W-1:0]    offset_q [NCH];
    logic [OUT_W-1:0]    offset_d [NCH];
    logic [ACC_W-1:0]    acc_q [NCH];
    logic [ACC_W-1:0]    acc_d [NCH];
    logic [CNT_W-1:0]    cnt_q [NCH];
    logic [CNT_W-1:0]    cnt_d [NCH];

    logic                out_valid_q, out_valid_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;

    logic [OUT_W-1:0]    diff;
    logic                all_done;

`ifdef DC_OFS_SAT_EN
    localparam logic [OUT_W-1:0] SAT_MAX = {{(OUT_W-ALIGN_W+1){1'b0}}, {(ALIGN_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = ~SAT_MAX;
    logic                out_sat_q, out_sat_d;
`endif

    // Stage 1: alignment and input qualification
    always_comb begin
        s1_valid_d   = in_valid && (int'({1'b0, in_ch}) < NCH);
        s1_ch_d      = in_ch;
        s1_aligned_d = ALIGN_W'(in_data) << FRAC_SHIFT;
    end

    // Stage 2: subtraction, optional clamp; outputs hold while idle
    always_comb begin
        diff        = OUT_W'(s1_aligned_q) - offset_q[s1_ch_q];
        out_valid_d = s1_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
`ifdef DC_OFS_SAT_EN
        out_sat_d   = out_sat_q;
`endif
        if (s1_valid_q) begin
            out_ch_d   = s1_ch_q;
            out_data_d = diff;
`ifdef DC_OFS_SAT_EN
            out_sat_d  = 1'b0;
            // In range only if every bit above the target sign bit matches it.
            if (!(&diff[OUT_W-1:ALIGN_W-1]) && (|diff[OUT_W-1:ALIGN_W-1])) begin
                out_sat_d  = 1'b1;
                out_data_d = diff[OUT_W-1] ? SAT_MIN : SAT_MAX;
            end
`endif
        end
    end

    // Calibration FSM and offset register update
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        // A write arriving during APPLY is dropped: calibration owns that edge.
        wr_pend_d = offset_wr && (state_q != APPLY);
        wr_ch_d   = offset_wr_ch;
        wr_data_d = offset_wr_data;

        all_done = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_q[i] != CAL_N) all_done = 1'b0;
        end

        if (wr_pend_q && (int'({1'b0, wr_ch_q}) < NCH)) begin
            offset_d[wr_ch_q] = wr_data_q;
        end

        case (state_q)
            IDLE: begin
                if (cal_start) begin
                    state_d = ACCUM;
                    for (int i = 0; i < NCH; i++) begin
                        acc_d[i] = '0;
                        cnt_d[i] = '0;
                    end
                end
            end
            ACCUM: begin
                if (s1_valid_q && (cnt_q[s1_ch_q] != CAL_N)) begin
                    acc_d[s1_ch_q] = acc_q[s1_ch_q] + ACC_W'(s1_aligned_q);
                    cnt_d[s1_ch_q] = cnt_q[s1_ch_q] + CNT_W'(1);
                end
                if (all_done) state_d = APPLY;
            end
            APPLY: begin
                // Assigned after the pending write so calibration wins.
                for (int i = 0; i < NCH; i++) begin
                    offset_d[i] = OUT_W'(acc_q[i] >> CAL_LOG2);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s1_valid_q   <= 1'b0;
            s1_ch_q      <= '0;
            s1_aligned_q <= '0;
            wr_pend_q    <= 1'b0;
            wr_ch_q      <= '0;
            wr_data_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
`ifdef DC_OFS_SAT_EN
            out_sat_q    <= 1'b0;
`endif
            for (int i = 0; i < NCH; i++) begin
                offset_q[i] <= DEFAULT_OFFSET;
                acc_q[i]    <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= s1_valid_d;
            s1_ch_q      <= s1_ch_d;
            s1_aligned_q <= s1_aligned_d;
            wr_pend_q    <= wr_pend_d;
            wr_ch_q      <= wr_ch_d;
            wr_data_q    <= wr_data_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_data_q   <= out_data_d;
`ifdef DC_OFS_SAT_EN
            out_sat_q    <= out_sat_d;
`endif
            for (int i = 0; i < NCH; i++) begin
                offset_q[i] <= offset_d[i];
                acc_q[i]    <= acc_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign cal_busy  = (state_q != IDLE);
    assign cal_done  = (state_q == APPLY);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
`ifdef DC_OFS_SAT_EN
    assign out_sat   = out_sat_q;
`else
    assign out_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_dc_offset_remover.sv
// tb/tb_dc_offset_remover.sv - self-checking bench for dc_offset_remover

module tb_dc_offset_remover;

    localparam int DATA_W   = 24;
    localparam int OUT_W    = 64;
    localparam int NCH      = 2;
    localparam int CH_W     = 1;
    localparam int CAL_LOG2 = 2;
    localparam logic [OUT_W-1:0] DEF_OFS = 64'h00000000AACCCCCD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [CH_W-1:0]   in_ch = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              offset_wr = 1'b0;
    logic [CH_W-1:0]   offset_wr_ch = '0;
    logic [OUT_W-1:0]  offset_wr_data = '0;
    logic              cal_start = 1'b0;
    logic              cal_busy, cal_done, out_valid, out_sat;
    logic [CH_W-1:0]   out_ch;
    logic [OUT_W-1:0]  out_data;

    dc_offset_remover #(
        .DATA_W(DATA_W), .FRAC_SHIFT(8), .OUT_W(OUT_W), .NCH(NCH),
        .CAL_LOG2(CAL_LOG2), .DEFAULT_OFFSET(DEF_OFS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .offset_wr(offset_wr), .offset_wr_ch(offset_wr_ch), .offset_wr_data(offset_wr_data),
        .cal_start(cal_start), .cal_busy(cal_busy), .cal_done(cal_done),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [OUT_W-1:0] data;
        logic             sat;
        int               due;
    } exp_t;

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] din;
        logic [OUT_W-1:0]  exp_plain;
        logic [OUT_W-1:0]  exp_clamp;
        logic              clamp;
    } vec_t;

    exp_t             sb[$];
    logic [OUT_W-1:0] ofs_m [NCH];

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        exp_t       e;
        logic [32:0] hi;
        e.ch   = ch;
        e.sat  = 1'b0;
        e.due  = 0;
        e.data = (OUT_W'(d) << 8) - ofs_m[ch];
`ifdef DC_OFS_SAT_EN
        hi = e.data[OUT_W-1:31];
        if (hi != '0 && hi != '1) begin
            e.sat  = 1'b1;
            e.data = e.data[OUT_W-1] ? 64'hFFFFFFFF80000000 : 64'h000000007FFFFFFF;
        end
`else
        hi = '0;
`endif
        return e;
    endfunction

    task automatic send(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d, input bit push,
                        input logic [OUT_W-1:0] exp_data, input logic exp_sat);
        exp_t e;
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        if (push) begin
            e.ch = ch; e.data = exp_data; e.sat = exp_sat; e.due = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] d);
        exp_t e;
        e = model(ch, d);
        send(ch, d, 1'b1, e.data, e.sat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got ch %0d data %h, required no output", out_ch, out_data);
            end else begin
                e = sb.pop_front();
                check("out_ch", OUT_W'(out_ch), OUT_W'(e.ch));
                check("out_data", out_data, e.data);
                check("out_sat", OUT_W'(out_sat), OUT_W'(e.sat));
                check("latency_cycle", OUT_W'(cyc), OUT_W'(e.due));
            end
        end
    end

    vec_t vecs[6];
    exp_t e1;
    bit   seen;

    initial begin
        vecs[0] = '{1'b0, 24'hAACCCD, 64'h0000000000000033, 64'h0000000000000033, 1'b0};
        vecs[1] = '{1'b1, 24'h000000, 64'hFFFFFFFF55333333, 64'hFFFFFFFF80000000, 1'b1};
        vecs[2] = '{1'b0, 24'hFFFFFF, 64'h0000000055333233, 64'h0000000055333233, 1'b0};
        vecs[3] = '{1'b1, 24'hAACCCC, 64'hFFFFFFFFFFFFFF33, 64'hFFFFFFFFFFFFFF33, 1'b0};
        vecs[4] = '{1'b0, 24'h2ACCCD, 64'hFFFFFFFF80000033, 64'hFFFFFFFF80000033, 1'b0};
        vecs[5] = '{1'b1, 24'h2ACCCC, 64'hFFFFFFFF7FFFFF33, 64'hFFFFFFFF80000000, 1'b1};
        for (int i = 0; i < NCH; i++) ofs_m[i] = DEF_OFS;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", OUT_W'(out_valid), 0);
        check("rst_out_ch", OUT_W'(out_ch), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", OUT_W'(out_sat), 0);
        check("rst_cal_busy", OUT_W'(cal_busy), 0);
        check("rst_cal_done", OUT_W'(cal_done), 0);
        rst = 1'b0;
        idle(1);

        // Back-to-back table vectors with default offsets
        for (int i = 0; i < 6; i++) begin
`ifdef DC_OFS_SAT_EN
            send(vecs[i].ch, vecs[i].din, 1'b1, vecs[i].exp_clamp, vecs[i].clamp);
`else
            send(vecs[i].ch, vecs[i].din, 1'b1, vecs[i].exp_plain, 1'b0);
`endif
        end
        idle(4);
        check("hold_out_valid", OUT_W'(out_valid), 0);
        check("hold_out_ch", OUT_W'(out_ch), 1);
`ifdef DC_OFS_SAT_EN
        check("hold_out_data", out_data, vecs[5].exp_clamp);
`else
        check("hold_out_data", out_data, vecs[5].exp_plain);
`endif

        // Offset write: same-cycle sample sees old value, next sample sees new
        offset_wr = 1'b1; offset_wr_ch = 1'b1; offset_wr_data = 64'h100;
`ifdef DC_OFS_SAT_EN
        send(1'b1, 24'h000001, 1'b1, 64'hFFFFFFFF80000000, 1'b1);
`else
        send(1'b1, 24'h000001, 1'b1, 64'hFFFFFFFF55333433, 1'b0);
`endif
        offset_wr = 1'b0;
        send(1'b1, 24'h000001, 1'b1, 64'h0, 1'b0);
        ofs_m[1] = 64'h100;

        // Zero offset on ch0 exposes the positive clamp boundary
        offset_wr = 1'b1; offset_wr_ch = 1'b0; offset_wr_data = 64'h0;
        idle(1);
        offset_wr = 1'b0;
        ofs_m[0] = 64'h0;
        send_m(1'b0, 24'hFFFFFF);
        send_m(1'b0, 24'h7FFFFF);
        send_m(1'b1, 24'h000000);
        idle(3);

        // Calibration with a redundant cal_start mid-run and a write in APPLY
        cal_start = 1'b1;
        idle(1);
        cal_start = 1'b0;
        check("cal_busy_after_start", OUT_W'(cal_busy), 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) cal_start = 1'b1;
            send_m(1'b0, 24'h100000);
            cal_start = 1'b0;
            send_m(1'b1, 24'h000010);
        end
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (cal_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL cal_done_timeout: got no cal_done in 30 cycles, required a pulse");
        end else begin
            check("cal_busy_in_apply", OUT_W'(cal_busy), 1);
            offset_wr = 1'b1; offset_wr_ch = 1'b0; offset_wr_data = 64'hDEAD;
            @(posedge clk); #1;
            offset_wr = 1'b0;
            check("cal_done_one_cycle", OUT_W'(cal_done), 0);
            check("cal_busy_cleared", OUT_W'(cal_busy), 0);
        end
        ofs_m[0] = 64'h10000000;
        ofs_m[1] = 64'h1000;
        send(1'b0, 24'h100001, 1'b1, 64'h100, 1'b0);
        send_m(1'b1, 24'h000010);
        idle(2);
        send_m(1'b0, 24'h100000);
        idle(3);

        // Reset in the middle of accumulation with samples in flight
        cal_start = 1'b1;
        idle(1);
        cal_start = 1'b0;
        send(1'b0, 24'h123456, 1'b0, 64'h0, 1'b0);
        in_valid = 1'b1; in_ch = 1'b1; in_data = 24'h000005;
        #2;
        rst = 1'b1;
        #1;
        in_valid = 1'b0;
        check("midrst_cal_busy", OUT_W'(cal_busy), 0);
        check("midrst_out_valid", OUT_W'(out_valid), 0);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) ofs_m[i] = DEF_OFS;
        idle(1);
        check("postrst_cal_busy", OUT_W'(cal_busy), 0);
        send(1'b0, 24'hAACCCD, 1'b1, 64'h33, 1'b0);
        send_m(1'b1, 24'h000000);
        idle(5);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_outputs: got %0d outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dc_offset_remover.md
Name: dc_offset_remover

Overview:
Multi-channel successor to the fixed 2.135 V DC-offset subtractor on the ADC path. It aligns each unsigned 24-bit ADC code into a wide fixed-point word and subtracts a per-channel offset. The offset is programmable at runtime or measured by an on-demand averaging calibration. It sits between the ADC capture interface and the downstream filter/ANC datapath, and carries a valid/channel tag alongside the data.

Parameters:
DATA_W, 24, ADC code width; codes are treated as unsigned and zero-extended.
FRAC_SHIFT, 8, left shift applied when aligning the code (code lands at bits [DATA_W+FRAC_SHIFT-1:FRAC_SHIFT]).
OUT_W, 64, output and offset word width; OUT_W >= DATA_W+FRAC_SHIFT+1.
NCH, 2, channel count; CH_W = max(1, clog2(NCH)).
CAL_LOG2, 10, calibration averages 2^CAL_LOG2 samples per channel.
DEFAULT_OFFSET, 64'h00000000AACCCCCD, reset offset for every channel (2.135 V at default alignment).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input sample strobe
in_ch  in  CH_W  channel of in_data; values >= NCH are dropped and produce no output
in_data  in  DATA_W  ADC code
offset_wr  in  1  write strobe for the offset register
offset_wr_ch  in  CH_W  target channel of the offset write
offset_wr_data  in  OUT_W  new offset value
cal_start  in  1  single-cycle pulse that starts calibration
cal_busy  out  1  high while calibration is in progress
cal_done  out  1  one-cycle pulse when calibrated offsets are applied
out_valid  out  1  output strobe
out_ch  out  CH_W  channel tag of out_data
out_data  out  OUT_W  signed result, aligned - offset[ch]
out_sat  out  1  saturation flag (see Optional Feature)

Behaviour:
- Reset values: out_valid, out_ch, out_data, out_sat, cal_busy, cal_done = 0; state = IDLE; all accumulators and counters = 0; offset[0..NCH-1] = DEFAULT_OFFSET.
- Pipeline, fixed latency of 2 cycles, no backpressure; one accepted sample per cycle.
  - Stage 1: register aligned = zero-extend(in_data) << FRAC_SHIFT, together with the channel tag and valid.
  - Stage 2: out_data <= aligned - offset[ch], computed at full OUT_W width in two's complement.
  - out_valid is asserted exactly 2 cycles after in_valid. The out_data and out_ch registers hold their last value while out_valid = 0.
- Offset write: takes effect from the next clock edge. A stage-2 subtraction in the same cycle as the write uses the old value.
- Calibration FSM:
  - IDLE: cal_start -> ACCUM. On entry, clear every acc[ch] and cnt[ch]; cal_busy = 1.
  - ACCUM: each valid sample with cnt[ch] < 2^CAL_LOG2 adds aligned to acc[ch] and increments cnt[ch]. Samples for a channel that has already reached its count are ignored for calibration but still pass through the datapath.
  - ACCUM -> APPLY once every channel has reached 2^CAL_LOG2.
  - APPLY (1 cycle): offset[ch] <= acc[ch] >> CAL_LOG2, zero-extended to OUT_W; cal_done = 1 for that cycle; then -> IDLE and cal_busy = 0.
  - Accumulator width is DATA_W+FRAC_SHIFT+CAL_LOG2 and must never overflow.
- The datapath keeps using the old offsets throughout ACCUM. The first sample to see a new offset is one whose stage-2 cycle follows the APPLY edge.
- cal_start while cal_busy = 1: ignored.
- offset_wr during ACCUM: accepted, but overwritten at APPLY.
- offset_wr in the APPLY cycle: calibration wins, and the write is discarded.
- A channel that never supplies samples leaves the FSM in ACCUM indefinitely. The only exit is rst.
- rst mid-calibration or mid-pipeline: immediately returns every register to its reset value, and in-flight samples are lost.

Optional Feature:
DC_OFS_SAT_EN
- Defined: the stage-2 result is clamped to the signed range of DATA_W+FRAC_SHIFT bits, i.e. [-2^31, 2^31-1] at defaults, then sign-extended to OUT_W. out_sat = 1 on exactly those outputs that were clamped.
- Undefined: plain OUT_W-bit subtraction; out_sat is tied to 0.
- Latency is 2 cycles in both builds.

Test Plan:
- Defaults, in_data = 24'hAACCCD on ch0 -> 2 cycles later out_valid = 1, out_ch = 0, out_data = 64'h33.
- in_data = 0 on ch1 -> out_data = 64'hFFFFFFFF55333333 (no macro); with DC_OFS_SAT_EN -> 64'hFFFFFFFF80000000 and out_sat = 1.
- offset_wr ch1 = 64'h100, then in_data = 24'h000001 on ch1 in the write cycle and the next cycle -> outputs 64'hFFFFFFFF55333433, then 64'h0.
- CAL_LOG2 = 2, NCH = 2: cal_start, 4 samples of 24'h100000 on ch0 and 4 of 24'h000010 on ch1 (interleaved) -> cal_done pulse, offsets 64'h10000000 and 64'h1000; then 24'h100001 on ch0 -> out_data = 64'h100.
- cal_start pulsed again during ACCUM, and offset_wr in the APPLY cycle -> neither has any effect; offsets equal the calibrated values.
- rst asserted mid-ACCUM with samples in flight -> cal_busy = 0, out_valid = 0 next edge, offsets = DEFAULT_OFFSET.
